// File: rtl/quad_encoder_pkg.sv
// quad_encoder_pkg
//   Shared definitions for the quadrature encoder bank:
//   - QS_* : the four two-bit {a,b} quadrature states
//   - step_e : outcome of comparing the previous and current quadrature state
//   - decode_step() : classifies one state transition for x1 or x4 decoding
package quad_encoder_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  // Clockwise (up) order is 00 -> 01 -> 11 -> 10 -> 00. A change of both
  // bits at once cannot be attributed to a direction and is an error.
  // In x1 mode only the legal transitions that land on 11 count, so each
  // detent produces exactly one step.
  function automatic step_e decode_step(input logic [1:0] prev,
                                        input logic [1:0] cur,
                                        input logic       x4);
    step_e s;
    case ({prev, cur})
      {QS_00, QS_01}, {QS_01, QS_11}, {QS_11, QS_10}, {QS_10, QS_00}: s = STEP_UP;
      {QS_01, QS_00}, {QS_11, QS_01}, {QS_10, QS_11}, {QS_00, QS_10}: s = STEP_DOWN;
      {QS_00, QS_11}, {QS_11, QS_00}, {QS_01, QS_10}, {QS_10, QS_01}: s = STEP_ERR;
      default: s = STEP_NONE;
    endcase
    if (!x4 && (s == STEP_UP || s == STEP_DOWN) && cur != QS_11) begin
      s = STEP_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// quad_encoder_channel
//   One encoder channel: two-flop synchroniser and history debouncer per pin,
//   quadrature decoder, and a bounded up/down counter (wrap or saturate).
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   a, b              : raw encoder pins (asynchronous)
//   clear             : synchronous reload of the counter to RESET_VAL
//   value [WIDTH-1:0] : registered counter
//   step              : one-cycle pulse when the counter is asked to move
//   dir               : direction of the last step, 1 = up
//   err               : one-cycle pulse on a two-bit quadrature jump
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int HIST_LEN   = 8,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 9,
  parameter int RESET_VAL  = 0,
  parameter int MODE_X4    = 0,
  parameter int SATURATE   = 0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

  // Bit 1 carries A, bit 0 carries B, matching the {a,b} state encoding.
  logic [1:0] pin;
  logic [1:0] db;

  assign pin = {a, b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pin
      logic [1:0]          sync_reg;
      logic [HIST_LEN-1:0] hist_reg;
      logic                db_reg;
      logic                db_next;

      // Only a history that is unanimous moves the debounced level, so any
      // run shorter than HIST_LEN samples leaves it where it was.
      always_comb begin
        db_next = db_reg;
        if (&hist_reg) begin
          db_next = 1'b1;
        end else if (~|hist_reg) begin
          db_next = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_reg <= {2{IDLE_LEVEL}};
          hist_reg <= {HIST_LEN{IDLE_LEVEL}};
          db_reg   <= IDLE_LEVEL;
        end else begin
          sync_reg <= {sync_reg[0], pin[gi]};
          hist_reg <= {hist_reg[HIST_LEN-2:0], sync_reg[1]};
          db_reg   <= db_next;
        end
      end

      assign db[gi] = db_reg;
    end
  endgenerate

  logic [1:0]       prev_reg;
  logic [WIDTH-1:0] value_reg;
  logic [WIDTH-1:0] value_next;
  logic             step_reg;
  logic             step_next;
  logic             dir_reg;
  logic             dir_next;
  logic             err_reg;
  logic             err_next;
  step_e            step_kind;

  always_comb begin
    step_kind  = decode_step(prev_reg, db, MODE_X4 != 0);
    value_next = value_reg;
    step_next  = 1'b0;
    dir_next   = dir_reg;
    err_next   = (step_kind == STEP_ERR);
    // clear wins over a simultaneous step; the decoder history still advances.
    if (clear) begin
      value_next = RESET_V;
    end else if (step_kind == STEP_UP) begin
      step_next = 1'b1;
      dir_next  = 1'b1;
      if (value_reg == MAX_V) begin
        value_next = (SATURATE != 0) ? value_reg : MIN_V;
      end else begin
        value_next = value_reg + WIDTH'(1);
      end
    end else if (step_kind == STEP_DOWN) begin
      step_next = 1'b1;
      dir_next  = 1'b0;
      if (value_reg == MIN_V) begin
        value_next = (SATURATE != 0) ? value_reg : MAX_V;
      end else begin
        value_next = value_reg - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg  <= {IDLE_LEVEL, IDLE_LEVEL};
      value_reg <= RESET_V;
      step_reg  <= 1'b0;
      dir_reg   <= 1'b1;
      err_reg   <= 1'b0;
    end else begin
      prev_reg  <= db;
      value_reg <= value_next;
      step_reg  <= step_next;
      dir_reg   <= dir_next;
      err_reg   <= err_next;
    end
  end

  assign value = value_reg;
  assign step  = step_reg;
  assign dir   = dir_reg;
  assign err   = err_reg;

endmodule

// File: rtl/quad_encoder_bank.sv
// quad_encoder_bank
//   Bank of CHANNELS independent quadrature encoder channels sharing one clock.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   a, b [CHANNELS]             : raw encoder pins (asynchronous)
//   clear [CHANNELS]            : per-channel synchronous reload to RESET_VAL
//   value [CHANNELS*WIDTH]      : counters, channel i at [i*WIDTH +: WIDTH]
//   step, dir, err [CHANNELS]   : per-channel step pulse, direction, error pulse
module quad_encoder_bank
  import quad_encoder_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 4,
  parameter int HIST_LEN   = 8,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 9,
  parameter int RESET_VAL  = 0,
  parameter int MODE_X4    = 0,
  parameter int SATURATE   = 0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       err
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      quad_encoder_channel #(
        .WIDTH      (WIDTH),
        .HIST_LEN   (HIST_LEN),
        .MIN_VAL    (MIN_VAL),
        .MAX_VAL    (MAX_VAL),
        .RESET_VAL  (RESET_VAL),
        .MODE_X4    (MODE_X4),
        .SATURATE   (SATURATE),
        .IDLE_LEVEL (IDLE_LEVEL)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a[gi]),
        .b       (b[gi]),
        .clear   (clear[gi]),
        .value   (value[gi*WIDTH +: WIDTH]),
        .step    (step[gi]),
        .dir     (dir[gi]),
        .err     (err[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_quad_encoder_bank.sv
module tb_quad_encoder_bank;

  localparam int HL   = 8;
  localparam int LAT  = HL + 4;  // negedge index of the output after the driving negedge
  localparam int MINV = 0;
  localparam int MAXV = 9;
  localparam int RSTV = 0;

  // Three copies share the pins: 0 = x1 wrap, 1 = x1 saturate, 2 = x4 wrap.
  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       a, b, clear;
  logic [2:0][7:0]  val_w;
  logic [2:0][1:0]  step_w, dir_w, err_w;

  typedef struct {
    int inst;
    int ch;
    bit is_err;
    int val;
    bit dir;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  int         exp_val[3][2];
  logic [1:0] pin_st[2];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         step_cnt[3];
  int         err_cnt[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_encoder_bank #(.HIST_LEN(HL), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV),
                      .MODE_X4(0), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clear(clear),
    .value(val_w[0]), .step(step_w[0]), .dir(dir_w[0]), .err(err_w[0]));
  quad_encoder_bank #(.HIST_LEN(HL), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV),
                      .MODE_X4(0), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clear(clear),
    .value(val_w[1]), .step(step_w[1]), .dir(dir_w[1]), .err(err_w[1]));
  quad_encoder_bank #(.HIST_LEN(HL), .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV),
                      .MODE_X4(1), .SATURATE(0)) u_x4 (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .clear(clear),
    .value(val_w[2]), .step(step_w[2]), .dir(dir_w[2]), .err(err_w[2]));

  function automatic int qpos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // 0 none, 1 up, 2 down, 3 error
  function automatic int classify(input logic [1:0] p, input logic [1:0] c, input bit x4);
    int d;
    d = (qpos(c) - qpos(p) + 4) % 4;
    if (d == 0) return 0;
    if (d == 2) return 3;
    if (!x4 && c != 2'b11) return 0;
    return (d == 1) ? 1 : 2;
  endfunction

  function automatic int bounded(input int v, input bit up, input bit sat);
    if (up) begin
      if (v == MAXV) return sat ? v : MINV;
      return v + 1;
    end
    if (v == MINV) return sat ? v : MAXV;
    return v - 1;
  endfunction

  // Drive channel ch to state ns and queue what each copy must produce.
  task automatic set_pins(input int ch, input logic [1:0] ns, input bit clr);
    int k;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      k = classify(pin_st[ch], ns, i == 2);
      if (k == 3) begin
        e = '{inst: i, ch: ch, is_err: 1'b1, val: exp_val[i][ch], dir: 1'b0, cyc: cyc + LAT};
        sb.push_back(e);
      end
      if (clr) begin
        exp_val[i][ch] = RSTV;
      end else if (k == 1 || k == 2) begin
        exp_val[i][ch] = bounded(exp_val[i][ch], k == 1, i == 1);
        e = '{inst: i, ch: ch, is_err: 1'b0, val: exp_val[i][ch], dir: (k == 1), cyc: cyc + LAT};
        sb.push_back(e);
      end
    end
    pin_st[ch] = ns;
    a[ch] = ns[1];
    b[ch] = ns[0];
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic detent_up(input int ch);
    set_pins(ch, 2'b10, 1'b0); hold(20);
    set_pins(ch, 2'b00, 1'b0); hold(20);
    set_pins(ch, 2'b01, 1'b0); hold(20);
    set_pins(ch, 2'b11, 1'b0); hold(20);
  endtask

  task automatic detent_down(input int ch);
    set_pins(ch, 2'b01, 1'b0); hold(20);
    set_pins(ch, 2'b00, 1'b0); hold(20);
    set_pins(ch, 2'b10, 1'b0); hold(20);
    set_pins(ch, 2'b11, 1'b0); hold(20);
  endtask

  // Pops the scoreboard whenever any copy pulses step or err.
  task automatic monitor_loop();
    int   found;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++) begin
          for (int kind = 0; kind < 2; kind++) begin
            if ((kind == 0 && step_w[i][c]) || (kind == 1 && err_w[i][c])) begin
              if (kind == 0) step_cnt[i]++; else err_cnt[i]++;
              found = -1;
              for (int k = 0; k < sb.size(); k++)
                if (found < 0 && sb[k].inst == i && sb[k].ch == c && sb[k].is_err == (kind == 1))
                  found = k;
              checks++;
              if (found < 0) begin
                errors++;
                $display("FAIL unexpected_%s inst=%0d ch=%0d cyc=%0d value=%0d", kind ? "err" : "step",
                         i, c, cyc, val_w[i][c*4 +: 4]);
              end else begin
                e = sb[found];
                sb.delete(found);
                if (cyc != e.cyc || (kind == 0 && (val_w[i][c*4 +: 4] !== 4'(e.val) || dir_w[i][c] !== e.dir))) begin
                  errors++;
                  $display("FAIL %s_match inst=%0d ch=%0d got val=%0d dir=%0b cyc=%0d, expected val=%0d dir=%0b cyc=%0d",
                           kind ? "err" : "step", i, c, val_w[i][c*4 +: 4], dir_w[i][c], cyc, e.val, e.dir, e.cyc);
                end else begin
                  $display("%s inst=%0d ch=%0d val=%0d dir=%0b cyc=%0d ok", kind ? "err " : "step",
                           i, c, val_w[i][c*4 +: 4], dir_w[i][c], cyc);
                end
              end
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset_n = 1'b0; a = 2'b11; b = 2'b11; clear = 2'b00;
    pin_st[0] = 2'b11; pin_st[1] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      exp_val[i][0] = RSTV; exp_val[i][1] = RSTV;
    end
    hold(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (val_w[i] !== 8'h00) begin errors++; $display("FAIL reset_value inst=%0d got=%h expected=00", i, val_w[i]); end
      checks++;
      if (step_w[i] !== 2'b00 || err_w[i] !== 2'b00) begin
        errors++; $display("FAIL reset_pulses inst=%0d step=%b err=%b expected 00", i, step_w[i], err_w[i]);
      end
      checks++;
      if (dir_w[i] !== 2'b11) begin errors++; $display("FAIL reset_dir inst=%0d got=%b expected=11", i, dir_w[i]); end
    end
    reset_n = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) pulses += $countones(step_w[i]) + $countones(err_w[i]);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL idle_after_reset pulses=%0d expected=0", pulses); end
    $display("reset: values=%h/%h/%h", val_w[0], val_w[1], val_w[2]);
  endtask

  task automatic test_x1_up();
    int s0;
    s0 = step_cnt[0];
    for (int d = 0; d < 4; d++) detent_up(0);
    checks++;
    if (val_w[0][3:0] !== 4'd4) begin errors++; $display("FAIL x1_up_value got=%0d expected=4", val_w[0][3:0]); end
    checks++;
    if (step_cnt[0] - s0 !== 4) begin errors++; $display("FAIL x1_up_steps got=%0d expected=4", step_cnt[0] - s0); end
    checks++;
    if (val_w[2][3:0] !== 4'd6) begin errors++; $display("FAIL x4_16_edges got=%0d expected=6", val_w[2][3:0]); end
  endtask

  task automatic test_wrap_sat();
    int s1;
    for (int d = 0; d < 5; d++) detent_up(0);
    checks++;
    if (val_w[0][3:0] !== 4'd9 || val_w[1][3:0] !== 4'd9) begin
      errors++; $display("FAIL reach_max got=%0d/%0d expected=9/9", val_w[0][3:0], val_w[1][3:0]);
    end
    s1 = step_cnt[1];
    detent_up(0);
    checks++;
    if (val_w[0][3:0] !== 4'd0) begin errors++; $display("FAIL wrap_up got=%0d expected=0", val_w[0][3:0]); end
    checks++;
    if (val_w[1][3:0] !== 4'd9 || step_cnt[1] - s1 !== 1) begin
      errors++; $display("FAIL sat_up got=%0d steps=%0d expected=9 steps=1", val_w[1][3:0], step_cnt[1] - s1);
    end
  endtask

  task automatic test_down_x4();
    detent_down(0);
    checks++;
    if (val_w[0][3:0] !== 4'd9) begin errors++; $display("FAIL wrap_down got=%0d expected=9", val_w[0][3:0]); end
    checks++;
    if (val_w[1][3:0] !== 4'd8) begin errors++; $display("FAIL sat_down got=%0d expected=8", val_w[1][3:0]); end
    set_pins(0, 2'b10, 1'b0); hold(20);
    set_pins(0, 2'b00, 1'b0); hold(20);
    set_pins(0, 2'b01, 1'b0); hold(20);
    checks++;
    if (val_w[2][3:0] !== 4'd9) begin errors++; $display("FAIL x4_at_max got=%0d expected=9", val_w[2][3:0]); end
    set_pins(0, 2'b11, 1'b0); hold(20);
    set_pins(0, 2'b10, 1'b0); hold(20);
    set_pins(0, 2'b00, 1'b0); hold(20);
    checks++;
    if (val_w[2][3:0] !== 4'd2 || val_w[0][3:0] !== 4'd0) begin
      errors++; $display("FAIL x4_wrap got=%0d/%0d expected=2/0", val_w[2][3:0], val_w[0][3:0]);
    end
    set_pins(0, 2'b01, 1'b0); hold(20);
    set_pins(0, 2'b11, 1'b0); hold(20);
  endtask

  task automatic test_glitch_err();
    int st, er;
    st = step_cnt[0] + step_cnt[1] + step_cnt[2];
    er = err_cnt[0];
    a[1] = 1'b0; hold(5); a[1] = 1'b1; hold(30);
    checks++;
    if (step_cnt[0] + step_cnt[1] + step_cnt[2] !== st || err_cnt[0] !== er) begin
      errors++; $display("FAIL glitch_reject extra steps=%0d errs=%0d expected 0/0",
                         step_cnt[0] + step_cnt[1] + step_cnt[2] - st, err_cnt[0] - er);
    end
    set_pins(1, 2'b00, 1'b0); hold(20);
    checks++;
    if (err_cnt[0] - er !== 1) begin errors++; $display("FAIL double_flip_err got=%0d expected=1", err_cnt[0] - er); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (val_w[i][7:4] !== 4'd0) begin errors++; $display("FAIL err_no_count inst=%0d got=%0d expected=0", i, val_w[i][7:4]); end
    end
    set_pins(1, 2'b11, 1'b0); hold(20);
  endtask

  task automatic test_clear_collision();
    set_pins(0, 2'b10, 1'b0); set_pins(1, 2'b10, 1'b0); hold(20);
    set_pins(0, 2'b00, 1'b0); set_pins(1, 2'b00, 1'b0); hold(20);
    set_pins(0, 2'b01, 1'b0); set_pins(1, 2'b01, 1'b0); hold(20);
    set_pins(0, 2'b11, 1'b1); set_pins(1, 2'b11, 1'b0);
    hold(LAT - 1);
    clear = 2'b01;
    hold(1);
    clear = 2'b00;
    checks++;
    if (step_w[0][0] !== 1'b0 || val_w[0][3:0] !== 4'd0) begin
      errors++; $display("FAIL clear_priority step=%b val=%0d expected step=0 val=0", step_w[0][0], val_w[0][3:0]);
    end
    checks++;
    if (step_w[0][1] !== 1'b1 || val_w[0][7:4] !== 4'd1) begin
      errors++; $display("FAIL clear_other_ch step=%b val=%0d expected step=1 val=1", step_w[0][1], val_w[0][7:4]);
    end
    hold(20);
  endtask

  task automatic test_reset_mid();
    int n;
    int e0;
    exp_t e;
    set_pins(0, 2'b10, 1'b0);
    hold(5);
    #3 reset_n = 1'b0;
    sb.delete();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (val_w[i] !== 8'h00 || step_w[i] !== 2'b00 || err_w[i] !== 2'b00 || dir_w[i] !== 2'b11) begin
        errors++; $display("FAIL async_reset inst=%0d val=%h step=%b err=%b dir=%b expected 00/00/00/11",
                           i, val_w[i], step_w[i], err_w[i], dir_w[i]);
      end
      exp_val[i][0] = RSTV; exp_val[i][1] = RSTV;
    end
    @(negedge clk);
    a = 2'b00; b = 2'b00; pin_st[0] = 2'b00; pin_st[1] = 2'b00;
    hold(3);
    e0 = err_cnt[0];
    n = cyc;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++) begin
        e = '{inst: i, ch: c, is_err: 1'b1, val: RSTV, dir: 1'b0, cyc: n + LAT};
        sb.push_back(e);
      end
    hold(30);
    checks++;
    if (err_cnt[0] - e0 !== 2 || val_w[0] !== 8'h00) begin
      errors++; $display("FAIL post_reset_err errs=%0d val=%h expected errs=2 val=00", err_cnt[0] - e0, val_w[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin step_cnt[i] = 0; err_cnt[i] = 0; end
    fork
      monitor_loop();
    join_none
    test_reset();
    test_x1_up();
    test_wrap_sat();
    test_down_x4();
    test_glitch_err();
    test_clear_collision();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
